// File: rtl/mipi_csi_pkg.sv
// mipi_csi_pkg: shared constants and types for the CSI-2 packet parser.
// Data-type codes, parser state encoding and fixed packet byte counts.
package mipi_csi_pkg;

   // Short-packet data types (synchronisation codes)
   localparam logic [5:0] DT_FS    = 6'h00;
   localparam logic [5:0] DT_FE    = 6'h01;
   localparam logic [5:0] DT_LS    = 6'h02;
   localparam logic [5:0] DT_LE    = 6'h03;
   // Long-packet image data types
   localparam logic [5:0] DT_RAW8  = 6'h2A;
   localparam logic [5:0] DT_RAW10 = 6'h2B;

   // Packet framing byte counts
   localparam int HDR_BYTES = 4;
   localparam int CRC_BYTES = 2;

   // Parser state, exposed on the top-level state_o debug port
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HDR2    = 3'd1,
      PAYLOAD = 3'd2,
      CRC     = 3'd3,
      SKIP    = 3'd4
   } parser_state_t;

endpackage

// File: rtl/csi_ecc_calc.sv
// csi_ecc_calc: combinational CSI-2 packet-header Hamming ECC.
// data = {WC[15:0], DI[7:0]}; ecc[5:0] are the six parity bits (ECC[7:6] are always 0).
// Only instantiated when CSI_ECC_CHECK_EN is defined.
module csi_ecc_calc (
   input  logic [23:0] data,
   output logic [5:0]  ecc
);

   // Each parity bit is the XOR of a fixed subset of the 24 header bits
   always_comb begin
      ecc[0] = ^(data & 24'hF12CB7);
      ecc[1] = ^(data & 24'hF2555B);
      ecc[2] = ^(data & 24'h749A6D);
      ecc[3] = ^(data & 24'hB8E38E);
      ecc[4] = ^(data & 24'hDF03F0);
      ecc[5] = ^(data & 24'hEFFC00);
   end

endmodule

// File: rtl/mipi_csi_packet_parser.sv
// mipi_csi_packet_parser: CSI-2 packet layer between the 2-lane byte aligner and the
// RAW10 unpacker. Decodes headers from 16-bit beats, turns short packets into
// FS/FE/LS/LE strobes and repacks accepted long-packet payload into 32-bit words.
// Optional feature macro: CSI_ECC_CHECK_EN (header ECC check, err_ecc_o live).
//
// Handshake: a beat is consumed on every rising edge where in_valid_i is high; a low
// in_valid_i freezes the parser. out_valid_o is a one-cycle strobe with no ready --
// the downstream must accept every word. At 2 bytes per beat at most one word per
// two cycles is produced.
module mipi_csi_packet_parser
   import mipi_csi_pkg::*;
#(
   parameter logic [5:0] DEF_DT = 6'h2B
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic [15:0] in_data_i,
   input  logic        in_valid_i,
   input  logic        in_sop_i,
   input  logic [5:0]  cfg_dt_i,
   output logic [31:0] out_data_o,
   output logic [3:0]  out_be_o,
   output logic        out_valid_o,
   output logic        out_eol_o,
   output logic        fs_o,
   output logic        fe_o,
   output logic        ls_o,
   output logic        le_o,
   output logic [15:0] frame_num_o,
   output logic [1:0]  hdr_vc_o,
   output logic [5:0]  hdr_dt_o,
   output logic [15:0] hdr_wc_o,
   output logic        err_trunc_o,
   output logic        err_ecc_o,
   output logic [2:0]  state_o
);

   parser_state_t state_q, state_d;
   logic [7:0]  di_q, di_d;
   logic [7:0]  wc_lo_q, wc_lo_d;
   logic [5:0]  acc_dt_q, acc_dt_d;
   logic [16:0] rem_q, rem_d;        // 17 bits so WC+2 never wraps
   logic [1:0]  idx_q, idx_d;        // next free byte lane of the assembly register
   logic [31:0] asm_q, asm_d;

   logic [31:0] word_d;
   logic [3:0]  be_d;
   logic        valid_d, eol_d;
   logic [3:0]  strobe_d;            // {le, ls, fe, fs}
   logic        trunc_d, hdr_upd, frame_upd;

   logic [15:0] wc_full;
   logic [5:0]  dt;
   logic [2:0]  n_bytes;
   logic [31:0] merged;
   logic        ecc_ok;

   assign dt      = di_q[5:0];
   assign wc_full = {in_data_i[7:0], wc_lo_q};
   // Byte count of the final word: bytes already held plus 1 or 2 from this beat
   assign n_bytes = {1'b0, idx_q} + ((rem_q == 17'd1) ? 3'd1 : 3'd2);
   assign state_o = state_q;

`ifdef CSI_ECC_CHECK_EN
   logic [5:0] ecc_calc;
   logic       ecc_bad_d;

   csi_ecc_calc u_ecc (
      .data ({wc_full, di_q}),
      .ecc  (ecc_calc)
   );
   assign ecc_ok = (ecc_calc == in_data_i[13:8]);
`else
   assign ecc_ok    = 1'b1;
   assign err_ecc_o = 1'b0;
`endif

   // Assembly register with this beat's payload byte(s) dropped in at idx
   always_comb begin
      merged = asm_q;
      merged[{idx_q, 3'b000} +: 8] = in_data_i[7:0];
      if (rem_q != 17'd1) merged[{idx_q + 2'd1, 3'b000} +: 8] = in_data_i[15:8];
   end

   // Next-state and next-output decode
   always_comb begin
      state_d   = state_q;
      di_d      = di_q;
      wc_lo_d   = wc_lo_q;
      acc_dt_d  = acc_dt_q;
      rem_d     = rem_q;
      idx_d     = idx_q;
      asm_d     = asm_q;
      word_d    = out_data_o;
      be_d      = out_be_o;
      valid_d   = 1'b0;
      eol_d     = 1'b0;
      strobe_d  = 4'b0000;
      trunc_d   = 1'b0;
      hdr_upd   = 1'b0;
      frame_upd = 1'b0;
`ifdef CSI_ECC_CHECK_EN
      ecc_bad_d = 1'b0;
`endif
      if (in_valid_i) begin
         if (in_sop_i) begin
            // A SOP always starts a header; inside a packet it aborts the old one
            trunc_d  = (state_q != IDLE);
            di_d     = in_data_i[7:0];
            wc_lo_d  = in_data_i[15:8];
            acc_dt_d = cfg_dt_i;
            asm_d    = '0;
            idx_d    = 2'd0;
            state_d  = HDR2;
         end else begin
            case (state_q)
               IDLE: state_d = IDLE;
               HDR2: begin
                  if (!ecc_ok) begin
`ifdef CSI_ECC_CHECK_EN
                     ecc_bad_d = 1'b1;
`endif
                     if (dt >= 6'h10) begin
                        rem_d   = {1'b0, wc_full} + 17'(CRC_BYTES);
                        state_d = SKIP;
                     end else begin
                        state_d = IDLE;
                     end
                  end else begin
                     hdr_upd = 1'b1;
                     if (dt <= 6'h0F) begin
                        if (dt <= DT_LE) strobe_d[dt[1:0]] = 1'b1;
                        frame_upd = (dt == DT_FS);
                        state_d   = IDLE;
                     end else if (dt == acc_dt_q) begin
                        rem_d   = {1'b0, wc_full};
                        state_d = (wc_full == 16'd0) ? CRC : PAYLOAD;
                     end else begin
                        rem_d   = {1'b0, wc_full} + 17'(CRC_BYTES);
                        state_d = SKIP;
                     end
                  end
               end
               PAYLOAD: begin
                  if (rem_q <= 17'd2) begin
                     // Last payload byte(s): flush whatever is assembled
                     word_d  = merged;
                     be_d    = 4'((5'd1 << n_bytes) - 5'd1);
                     valid_d = 1'b1;
                     eol_d   = 1'b1;
                     asm_d   = '0;
                     idx_d   = 2'd0;
                     rem_d   = '0;
                     state_d = CRC;
                  end else begin
                     rem_d = rem_q - 17'd2;
                     if (idx_q == 2'd2) begin
                        word_d  = merged;
                        be_d    = 4'hF;
                        valid_d = 1'b1;
                        asm_d   = '0;
                        idx_d   = 2'd0;
                     end else begin
                        asm_d = merged;
                        idx_d = idx_q + 2'd2;
                     end
                  end
               end
               // One beat always covers the 1 or 2 remaining CRC bytes
               CRC: state_d = IDLE;
               SKIP: begin
                  if (rem_q <= 17'd2) state_d = IDLE;
                  else rem_d = rem_q - 17'd2;
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end

   // Parser state register
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) state_q <= IDLE;
      else            state_q <= state_d;
   end

   // Packet context: header bytes, accepted DT, byte counter, word assembly
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         di_q     <= '0;
         wc_lo_q  <= '0;
         acc_dt_q <= DEF_DT;
         rem_q    <= '0;
         idx_q    <= '0;
         asm_q    <= '0;
      end else begin
         di_q     <= di_d;
         wc_lo_q  <= wc_lo_d;
         acc_dt_q <= acc_dt_d;
         rem_q    <= rem_d;
         idx_q    <= idx_d;
         asm_q    <= asm_d;
      end
   end

   // Registered outputs: word port, strobes, header fields, errors
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         out_data_o  <= '0;
         out_be_o    <= '0;
         out_valid_o <= 1'b0;
         out_eol_o   <= 1'b0;
         fs_o        <= 1'b0;
         fe_o        <= 1'b0;
         ls_o        <= 1'b0;
         le_o        <= 1'b0;
         frame_num_o <= '0;
         hdr_vc_o    <= '0;
         hdr_dt_o    <= '0;
         hdr_wc_o    <= '0;
         err_trunc_o <= 1'b0;
      end else begin
         out_data_o  <= word_d;
         out_be_o    <= be_d;
         out_valid_o <= valid_d;
         out_eol_o   <= eol_d;
         fs_o        <= strobe_d[0];
         fe_o        <= strobe_d[1];
         ls_o        <= strobe_d[2];
         le_o        <= strobe_d[3];
         err_trunc_o <= trunc_d;
         if (frame_upd) frame_num_o <= wc_full;
         if (hdr_upd) begin
            hdr_vc_o <= di_q[7:6];
            hdr_dt_o <= dt;
            hdr_wc_o <= wc_full;
         end
      end
   end

`ifdef CSI_ECC_CHECK_EN
   // ECC mismatch pulse
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) err_ecc_o <= 1'b0;
      else            err_ecc_o <= ecc_bad_d;
   end
`endif

endmodule

// File: tb/tb_mipi_csi_packet_parser.sv
// tb_mipi_csi_packet_parser: directed packet bench for mipi_csi_packet_parser.
// A packet-level model turns each queued packet into expected words and strobe
// events; a monitor compares every DUT word/strobe against those queues.
// Honours CSI_ECC_CHECK_EN for the ECC-error scenario.
module tb_mipi_csi_packet_parser;
   import mipi_csi_pkg::*;

`ifdef CSI_ECC_CHECK_EN
   localparam bit ECC_EN = 1'b1;
`else
   localparam bit ECC_EN = 1'b0;
`endif

   // CSI-2 ECC column code of each header bit D0..D23
   localparam logic [5:0] ECC_COL [24] = '{
      6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
      6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
      6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

   // ---------------- clock / reset / DUT ----------------
   logic        clk_i = 1'b0;
   logic        reset_n_i;
   logic [15:0] in_data_i;
   logic        in_valid_i, in_sop_i;
   logic [5:0]  cfg_dt_i;
   logic [31:0] out_data_o;
   logic [3:0]  out_be_o;
   logic        out_valid_o, out_eol_o, fs_o, fe_o, ls_o, le_o;
   logic [15:0] frame_num_o, hdr_wc_o;
   logic [1:0]  hdr_vc_o;
   logic [5:0]  hdr_dt_o;
   logic        err_trunc_o, err_ecc_o;
   logic [2:0]  state_o;

   always #5 clk_i = ~clk_i;

   mipi_csi_packet_parser #(.DEF_DT(6'h2B)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .in_data_i(in_data_i),
      .in_valid_i(in_valid_i), .in_sop_i(in_sop_i), .cfg_dt_i(cfg_dt_i),
      .out_data_o(out_data_o), .out_be_o(out_be_o), .out_valid_o(out_valid_o),
      .out_eol_o(out_eol_o), .fs_o(fs_o), .fe_o(fe_o), .ls_o(ls_o), .le_o(le_o),
      .frame_num_o(frame_num_o), .hdr_vc_o(hdr_vc_o), .hdr_dt_o(hdr_dt_o),
      .hdr_wc_o(hdr_wc_o), .err_trunc_o(err_trunc_o), .err_ecc_o(err_ecc_o),
      .state_o(state_o));

   // ---------------- scoreboard / model state ----------------
   typedef struct packed {
      logic [5:0]  flags;   // {trunc, ecc, fs, fe, ls, le}
      logic        chk_hdr;
      logic [15:0] frame;
      logic [1:0]  vc;
      logic [5:0]  dt;
      logic [15:0] wc;
   } ev_t;

   int          checks = 0;
   int          errors = 0;
   logic [36:0] exp_q[$];      // {eol, be, data}
   logic [36:0] act_log[$];
   ev_t         ev_q[$];
   logic [16:0] beat_q[$];     // {sop, data}
   logic [15:0] m_frame, m_wc;
   logic [1:0]  m_vc;
   logic [5:0]  m_dt, m_cfg;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] ecc_of(input logic [23:0] d);
      logic [5:0] s;
      s = 6'h00;
      for (int i = 0; i < 24; i++) if (d[i]) s ^= ECC_COL[i];
      return {2'b00, s};
   endfunction

   // Queue the beats of one packet and what the parser must produce for it.
   // cut >= 0: only 'cut' payload bytes are sent; sop_next: a SOP follows (trunc).
   function automatic void add_packet(input logic [7:0] di, input logic [15:0] wc,
                                      input logic [7:0] b0, input bit flip,
                                      input int cut, input bit sop_next);
      logic [7:0]  bytes[$];
      logic [7:0]  e;
      logic [5:0]  dt;
      logic [31:0] w;
      int          n, k;
      bit          long_pkt;
      ev_t         ev;
      dt       = di[5:0];
      long_pkt = (dt >= 6'h10);
      e        = ecc_of({wc, di});
      if (flip) e ^= 8'h04;
      beat_q.push_back({1'b1, wc[7:0], di});
      beat_q.push_back({1'b0, e, wc[15:8]});
      n = (cut >= 0) ? cut : int'(wc);
      if (long_pkt) begin
         for (int i = 0; i < n; i++) bytes.push_back(8'(b0 + i));
         if (cut < 0) begin
            bytes.push_back(8'hAA);
            bytes.push_back(8'hBB);
         end
         for (int i = 0; i < bytes.size(); i += 2)
            beat_q.push_back({1'b0, (i + 1 < bytes.size()) ? bytes[i+1] : 8'h00, bytes[i]});
      end
      ev = '0;
      if (flip && ECC_EN) begin
         ev.flags = 6'b010000;
         ev_q.push_back(ev);
      end else begin
         m_vc = di[7:6];
         m_dt = dt;
         m_wc = wc;
         if (!long_pkt) begin
            if (dt == 6'h00) m_frame = wc;
            if (dt <= 6'h03) begin
               ev.flags   = 6'b001000 >> dt;
               ev.chk_hdr = 1'b1;
               ev.frame   = m_frame;
               ev.vc      = m_vc;
               ev.dt      = m_dt;
               ev.wc      = m_wc;
               ev_q.push_back(ev);
            end
         end else if (dt == m_cfg) begin
            for (int i = 0; i < n; i += 4) begin
               k = (n - i > 4) ? 4 : n - i;
               if (cut >= 0 && k < 4) break;
               w = '0;
               for (int j = 0; j < k; j++) w[8*j +: 8] = bytes[i+j];
               exp_q.push_back({(cut < 0) && (i + k == n), 4'((1 << k) - 1), w});
            end
         end
      end
      if (sop_next) begin
         ev       = '0;
         ev.flags = 6'b100000;
         ev_q.push_back(ev);
      end
   endfunction

   // ---------------- driver ----------------
   task automatic run(input bit stall);
      logic [16:0] b;
      bit          gap;
      gap = 1'b0;
      while (beat_q.size() > 0) begin
         @(negedge clk_i);
         if (stall && gap) begin
            in_valid_i = 1'b0;
            in_sop_i   = 1'($urandom_range(0, 1));
            in_data_i  = 16'($urandom_range(0, 65535));
         end else begin
            b          = beat_q.pop_front();
            in_valid_i = 1'b1;
            in_sop_i   = b[16];
            in_data_i  = b[15:0];
         end
         gap = !gap;
      end
      @(negedge clk_i);
      in_valid_i = 1'b0;
      in_sop_i   = 1'b0;
      repeat (3) @(negedge clk_i);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_state"}, 64'(state_o), 64'(IDLE));
      check({tag, "_hdr"}, {hdr_vc_o, hdr_dt_o, hdr_wc_o}, {m_vc, m_dt, m_wc});
      check({tag, "_frame"}, frame_num_o, m_frame);
      check({tag, "_words_left"}, exp_q.size(), 0);
      check({tag, "_events_left"}, ev_q.size(), 0);
      exp_q.delete();
      ev_q.delete();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_outs"}, {out_data_o, out_be_o, out_valid_o, out_eol_o, fs_o, fe_o,
                             ls_o, le_o, err_trunc_o, err_ecc_o}, 0);
      check({tag, "_hdr"}, {frame_num_o, hdr_vc_o, hdr_dt_o, hdr_wc_o}, 0);
      check({tag, "_state"}, 64'(state_o), 64'(IDLE));
   endtask

   // ---------------- monitor / compare ----------------
   initial begin
      logic [5:0] fl;
      ev_t        ev;
      forever begin
         @(posedge clk_i);
         #2;
         if (reset_n_i) begin
            if (out_valid_o) begin
               act_log.push_back({out_eol_o, out_be_o, out_data_o});
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL word_unexpected: got %0h expected none",
                           {out_eol_o, out_be_o, out_data_o});
               end else begin
                  check("word", {out_eol_o, out_be_o, out_data_o}, exp_q.pop_front());
               end
            end
            fl = {err_trunc_o, err_ecc_o, fs_o, fe_o, ls_o, le_o};
            if (fl != 6'b0) begin
               if (ev_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL event_unexpected: got %0h expected none", fl);
               end else begin
                  ev = ev_q.pop_front();
                  check("event_flags", fl, ev.flags);
                  if (ev.chk_hdr) begin
                     check("event_frame", frame_num_o, ev.frame);
                     check("event_hdr", {hdr_vc_o, hdr_dt_o, hdr_wc_o}, {ev.vc, ev.dt, ev.wc});
                  end
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int base, base2;
      reset_n_i  = 1'b0;
      in_data_i  = '0;
      in_valid_i = 1'b0;
      in_sop_i   = 1'b0;
      cfg_dt_i   = 6'h2B;
      m_cfg      = 6'h2B;
      m_frame    = '0;
      m_wc       = '0;
      m_vc       = '0;
      m_dt       = '0;
      repeat (3) @(negedge clk_i);
      check_zero("reset");
      reset_n_i = 1'b1;
      @(negedge clk_i);

      // Frame Start, frame number 1
      add_packet(8'h00, 16'h0001, 8'h00, 1'b0, -1, 1'b0);
      run(1'b0);
      check("fs_frame_literal", frame_num_o, 16'h0001);
      check_idle("fs");

      // RAW10 WC=5, payload 0x11..0x15
      base = act_log.size();
      add_packet(8'h2B, 16'd5, 8'h11, 1'b0, -1, 1'b0);
      run(1'b0);
      check("raw10_count", act_log.size() - base, 2);
      if (act_log.size() >= base + 2) begin
         check("raw10_w0_literal", act_log[base], {1'b0, 4'hF, 32'h14131211});
         check("raw10_w1_literal", act_log[base+1], {1'b1, 4'h1, 32'h00000015});
      end
      check_idle("raw10");

      // Non-matching RAW8 skipped, following FS still decoded
      add_packet(8'h2A, 16'd8, 8'h30, 1'b0, -1, 1'b0);
      add_packet(8'h00, 16'h0002, 8'h00, 1'b0, -1, 1'b0);
      run(1'b0);
      check_idle("skip_dt");

      // SOP after 6 payload bytes of WC=10, then an LS header
      add_packet(8'h2B, 16'd10, 8'h40, 1'b0, 6, 1'b1);
      add_packet(8'h02, 16'h0007, 8'h00, 1'b0, -1, 1'b0);
      run(1'b0);
      check_idle("trunc");

      // WC=16 unstalled then with in_valid_i toggling every cycle
      base = act_log.size();
      add_packet(8'h2B, 16'd16, 8'h50, 1'b0, -1, 1'b0);
      run(1'b0);
      base2 = act_log.size();
      add_packet(8'h2B, 16'd16, 8'h50, 1'b0, -1, 1'b0);
      run(1'b1);
      check("stall_count", act_log.size() - base2, 4);
      if (act_log.size() == base2 + 4 && base2 == base + 4)
         for (int i = 0; i < 4; i++) check("stall_same", act_log[base2+i], act_log[base+i]);
      check_idle("stall");

      // Boundary lengths, other strobes, a generic short DT and a nonzero VC
      add_packet(8'h2B, 16'd0, 8'h00, 1'b0, -1, 1'b0);
      add_packet(8'h2B, 16'd2, 8'hC1, 1'b0, -1, 1'b0);
      add_packet(8'h2B, 16'd4, 8'hD1, 1'b0, -1, 1'b0);
      add_packet(8'h6B, 16'd7, 8'hE1, 1'b0, -1, 1'b0);
      add_packet(8'h01, 16'h0003, 8'h00, 1'b0, -1, 1'b0);
      add_packet(8'hC3, 16'h1234, 8'h00, 1'b0, -1, 1'b0);
      add_packet(8'h08, 16'hBEEF, 8'h00, 1'b0, -1, 1'b0);
      run(1'b0);
      check_idle("bounds");

      // Reconfigure to RAW8: RAW8 accepted, RAW10 now skipped
      cfg_dt_i = 6'h2A;
      m_cfg    = 6'h2A;
      add_packet(8'h2A, 16'd6, 8'h70, 1'b0, -1, 1'b0);
      add_packet(8'h2B, 16'd4, 8'h80, 1'b0, -1, 1'b0);
      run(1'b0);
      check_idle("raw8");
      cfg_dt_i = 6'h2B;
      m_cfg    = 6'h2B;

      // Maximum WC skipped without counter wrap, then FE
      add_packet(8'h2C, 16'hFFFF, 8'h00, 1'b0, -1, 1'b0);
      add_packet(8'h01, 16'h0004, 8'h00, 1'b0, -1, 1'b0);
      run(1'b0);
      check_idle("wc_max");

`ifdef CSI_ECC_CHECK_EN
      // Bad ECC on LS and on a long packet; FS afterwards decoded normally
      add_packet(8'h02, 16'h0055, 8'h00, 1'b1, -1, 1'b0);
      add_packet(8'h2B, 16'd3, 8'h90, 1'b1, -1, 1'b0);
      add_packet(8'h00, 16'h0009, 8'h00, 1'b0, -1, 1'b0);
      run(1'b0);
      check_idle("ecc");
`endif

      // Reset in the middle of a payload aborts silently
      add_packet(8'h2B, 16'd16, 8'hA0, 1'b0, 6, 1'b0);
      run(1'b0);
      check("pre_reset_words_left", exp_q.size(), 0);
      @(negedge clk_i);
      reset_n_i = 1'b0;
      #1;
      check_zero("mid_reset");
      m_frame = '0;
      m_vc    = '0;
      m_dt    = '0;
      m_wc    = '0;
      exp_q.delete();
      ev_q.delete();
      repeat (2) @(negedge clk_i);
      reset_n_i = 1'b1;
      @(negedge clk_i);
      add_packet(8'h00, 16'h0021, 8'h00, 1'b0, -1, 1'b0);
      run(1'b0);
      check_idle("after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
